regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised, clocked register file; successor to the current combinational-write register block in the datapath.
- Provides NUM_RD registered read ports, one write port with word/halfword/byte merge modes, and write-to-read bypass.
- Holds a per-register busy scoreboard: the decode stage reserves a register for a multicycle producer (load, mul), and writeback releases it.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits; must be >= 16.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data, packed the same way.
- rd_busy  out  NUM_RD  registered busy flag for the address last read on each port.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_mode  in  2  00 = word, 01 = byte [7:0], 10 = halfword [15:0], 11 = word.
- rsv_en  in  1  reserve request.
- rsv_addr  in  ADDR_W  register to mark busy.
- busy_vec  out  2**ADDR_W  registered scoreboard, one bit per register.

Behaviour:
- Reset (rst_n low, asynchronous): all registers, rd_data, rd_busy and busy_vec go to 0. Reset held mid-operation discards any pending write or reserve. The first edge after deassertion behaves normally.
- Write: on a rising edge with wr_en=1, mem[wr_addr] takes the merged value.
  - Word mode: merged = wr_data.
  - Byte mode: only bits [7:0] are replaced; upper bits keep their old value.
  - Halfword mode: only bits [15:0] are replaced; upper bits keep their old value.
  - No sign or zero extension is performed.
  - With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: 1-cycle latency.
  - On a rising edge with rd_en[i]=1, rd_data[i] takes mem[rd_addr[i]] and rd_busy[i] takes the busy bit.
  - With rd_en[i]=0, both outputs hold their previous values.
  - Multiple ports reading the same address are independent and each returns the same value.
- Bypass: if wr_en=1 and wr_addr==rd_addr[i] on the same edge (and the address is not a suppressed register 0), rd_data[i] gets the merged new value, not the stale one.
- Scoreboard update per edge, in priority order:
  1. rsv_en with rsv_addr sets busy[rsv_addr].
  2. Otherwise wr_en with wr_addr clears busy[wr_addr].
  - Reserve and write to the same address on the same edge: busy stays 1, because the new producer wins; the data write still happens.
  - Reserve and write to different addresses on the same edge: both take effect.
  - Reserving a register that is already busy: it stays busy, with no error.
  - With ZERO_REG=1, busy[0] is constant 0.
- rd_busy bypass: rd_busy[i] reflects the post-edge scoreboard value for that address. A same-edge write clears it, and a same-edge reserve sets it.
- busy_vec always shows the current registered scoreboard.
- No combinational path from any input to any output.

Test Plan:
- Reset and read: assert rst_n=0 mid-run, release, then read addresses 5 and 31 on ports 0 and 1 -> rd_data = 0 on both, rd_busy = 0, busy_vec = 0.
- Word write then read: write 0xDEADBEEF to address 7 in word mode, then read address 7 on the next cycle -> rd_data[0] = 0xDEADBEEF one cycle after rd_en.
- Sub-word merge: reg 7 holds 0xDEADBEEF.
  - Byte write of 0x00000012 -> reg 7 reads 0xDEADBE12.
  - Halfword write of 0x0000ABCD -> reg 7 reads 0xDEADABCD.
- Bypass and zero register:
  - Same edge: write 0x11223344 to address 3 and read address 3 on both ports -> both rd_data = 0x11223344.
  - Write 0xFFFFFFFF to address 0 -> reading address 0 returns 0.
- Scoreboard:
  - Reserve address 9 -> busy_vec[9] = 1, and a read of address 9 shows rd_busy = 1.
  - Write address 9 -> busy cleared.
  - Same edge: reserve and write address 9 -> busy stays 1 and data is updated.
  - Same edge: reserve address 4 and write address 9 -> busy[4] = 1, busy[9] = 0.
- Hold behaviour: with rd_en=0 while address 3 changes, rd_data and rd_busy stay unchanged. With rd_en=1 on the next cycle, they show the new value.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, sub-word write merge,
// write-to-read bypass and a per-register busy scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [1:0]               wr_mode,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] merged;
  logic              wr_ok;
  logic [DEPTH-1:0]  busy_nxt;

  always_comb begin
    case (wr_mode)
      2'b01:   wr_mask = DATA_W'(16'h00FF);
      2'b10:   wr_mask = DATA_W'(16'hFFFF);
      default: wr_mask = '1;
    endcase
    merged = (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
    wr_ok  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  end

  // Clear before set so a same-address reserve wins over the releasing write.
  always_comb begin
    busy_nxt = busy_vec;
    if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy_vec <= '0;
    end else begin
      if (wr_ok) mem[wr_addr] <= merged;
      busy_vec <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          if (wr_ok && (wr_addr == rd_addr[i*ADDR_W +: ADDR_W]))
            rd_data[i*DATA_W +: DATA_W] <= merged;
          else if ((ZERO_REG != 0) && (rd_addr[i*ADDR_W +: ADDR_W] == '0))
            rd_data[i*DATA_W +: DATA_W] <= '0;
          else
            rd_data[i*DATA_W +: DATA_W] <= mem[rd_addr[i*ADDR_W +: ADDR_W]];
          rd_busy[i] <= busy_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (DATA_W=32, ADDR_W=5, NUM_RD=2).
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_mode;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [31:0] busy_vec;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mode(wr_mode), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 2'b00; wr_en = 1'b0; rsv_en = 1'b0; wr_mode = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Populate state, then assert reset mid-run with a write pending.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAAAA5555; rsv_en = 1'b1; rsv_addr = 5'd31;
    step();
    wr_addr = 5'd31; wr_data = 32'h12345678; rsv_en = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    step();
    chk("pre_reset_rd0", rd_data[31:0], 32'hAAAA5555);
    chk("pre_reset_busy", busy_vec, 32'h0000_0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_rd", rd_data, 64'h0);
    chk("async_reset_busy", busy_vec, 32'h0);
    step();
    idle();
    step();
    rst_n = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    step();
    idle();
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_rd_busy", rd_busy, 2'b00);
    chk("reset_busy_vec", busy_vec, 32'h0);

    // Word write then read.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; wr_mode = 2'b00;
    step(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    step(); idle();
    chk("word_write", rd_data[31:0], 32'hDEADBEEF);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000012; wr_mode = 2'b01;
    step(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    step(); idle();
    chk("byte_merge", rd_data[31:0], 32'hDEADBE12);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000ABCD; wr_mode = 2'b10;
    step(); idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    step(); idle();
    chk("half_merge", rd_data[63:32], 32'hDEADABCD);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h01020304; wr_mode = 2'b11;
    step(); idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    step(); idle();
    chk("mode3_word", rd_data[31:0], 32'h01020304);

    // Same-edge bypass on both ports.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11223344;
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    step(); idle();
    chk("bypass_p0", rd_data[31:0], 32'h11223344);
    chk("bypass_p1", rd_data[63:32], 32'h11223344);

    // Register zero: same-edge write is not bypassed, later read is zero.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    step(); idle();
    chk("zero_bypass", rd_data[31:0], 32'h0);
    rd_en = 2'b10; rd_addr = {5'd0, 5'd0};
    step(); idle();
    chk("zero_read", rd_data[63:32], 32'h0);

    // Scoreboard.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step(); idle();
    chk("rsv9_vec", busy_vec, 32'h0000_0200);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    step(); idle();
    chk("rsv9_rd_busy", rd_busy[0], 1'b1);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    step(); idle();
    chk("wr9_clear_vec", busy_vec, 32'h0);
    chk("wr9_rd_busy_bypass", rd_busy[0], 1'b0);
    chk("wr9_rd_data", rd_data[31:0], 32'h00000099);

    rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000055;
    rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
    step(); idle();
    chk("rsvwr9_vec", busy_vec, 32'h0000_0200);
    chk("rsvwr9_rd_busy", rd_busy[1], 1'b1);
    chk("rsvwr9_rd_data", rd_data[63:32], 32'h00000055);

    rsv_en = 1'b1; rsv_addr = 5'd4; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000066;
    step(); idle();
    chk("rsv4_wr9_vec", busy_vec, 32'h0000_0010);

    // Hold: read 3, then change it with rd_en low.
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    step(); idle();
    chk("hold_pre", rd_data, 64'h11223344_11223344);
    rsv_en = 1'b1; rsv_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000077;
    step(); idle();
    chk("hold_data", rd_data, 64'h11223344_11223344);
    chk("hold_busy", rd_busy, 2'b00);
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    step(); idle();
    chk("hold_release_data", rd_data, 64'h00000077_00000077);
    chk("hold_release_busy", rd_busy, 2'b11);

    // Reserving register zero never sets its busy bit.
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    step(); idle();
    chk("rsv0_vec", busy_vec, 32'h0000_0018);
    chk("rsv0_rd_busy", rd_busy[0], 1'b0);

    // Re-reserving a busy register keeps it busy.
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step(); idle();
    chk("rsv4_again", busy_vec, 32'h0000_0018);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
